mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted while 0.
REQ-005 E_start  input  1  EX-stage MDU instruction valid this cycle.
REQ-006 E_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-007 E_A  input  32  rs operand (forwarded).
REQ-008 E_B  input  32  rt operand (forwarded).
REQ-009 D_is_mdu  input  1  ID-stage instruction is any MDU op (0-7).
REQ-010 E_MDU_Result  output  32  MFHI/MFLO read data, fed to the EX/MEM register.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 stall  output  1  freeze PC/IF-ID, bubble ID-EX.
REQ-013 done  output  1  one-cycle pulse after HI/LO commit of a mult/div.

Function
REQ-014 States SHALL be IDLE, MUL, DIV; busy = (state != IDLE), registered.
REQ-015 In IDLE, E_start with E_op 0/1 SHALL at that edge latch {pend_hi,pend_lo} = 64-bit product (signed for 0, unsigned for 1), load cnt = MULT_CYCLES, go to MUL.
REQ-016 In IDLE, E_start with E_op 2/3 SHALL latch pend_lo = quotient, pend_hi = remainder (signed for 2, unsigned for 3), load cnt = DIV_CYCLES, go to DIV.
REQ-017 Signed divide: quotient truncates toward zero; remainder takes sign of dividend; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 Divide by zero: SHALL still go busy for DIV_CYCLES, then leave HI/LO unchanged; done still pulses.
REQ-019 In MUL/DIV each edge SHALL decrement cnt; at the edge where cnt==1: HI<=pend_hi, LO<=pend_lo (except REQ-018), state<=IDLE.
REQ-020 busy SHALL be high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), from the cycle after the start edge.
REQ-021 done SHALL be high exactly the first cycle after commit, else 0.
REQ-022 In IDLE, E_start with E_op 6/7 SHALL write E_A to HI/LO respectively at that edge; no busy.
REQ-023 E_MDU_Result SHALL be combinational: HI when E_op=4, LO when E_op=5, else 0; it reflects the register value, never pending data.
REQ-024 E_start while busy SHALL be ignored (no state, HI/LO or cnt change).
REQ-025 stall = D_is_mdu & (busy | (E_start & E_op<=3)), combinational.
REQ-026 Back-to-back: a start in the cycle immediately after busy falls SHALL be accepted normally.
REQ-027 E_MDU_Result, busy, done SHALL have no X when inputs are known.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, cnt=0, HI=LO=0, pend_hi=pend_lo=0, busy=0, done=0, independent of clk.
REQ-029 Reset mid-operation SHALL discard pending results; HI/LO read 0 after release.
REQ-030 First edge after reset release SHALL accept E_start normally.

Verification
REQ-031 MULT A=0xFFFFFFFD, B=5 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, done 1 cycle; MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
REQ-032 DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-033 MTHI 0x12345678 then MFHI next cycle -> E_MDU_Result=0x12345678; DIV x/0 with prior HI/LO=0x12345678/0 -> unchanged after 10 cycles.
REQ-034 MULT start with D_is_mdu=1 held -> stall high in start cycle and all 5 busy cycles, low the cycle after; second start during busy ignored.
REQ-035 reset pulled low in cycle 3 of DIV -> busy=0 immediately, HI=LO=0, no done pulse; new MULTU accepted on first edge after release.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds HI/LO, runs fixed-latency MULT/DIV
// sequences and generates the pipeline stall and commit-done pulse.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_mdu,
  output logic [31:0] E_MDU_Result,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // Operands widened by sign or zero extension so one signed multiplier
  // covers both MULT and MULTU; the low 64 bits are the exact product.
  function automatic logic [2*DATA_W-1:0] mul_core(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              is_signed
  );
    logic signed [2*DATA_W+1:0] sa;
    logic signed [2*DATA_W+1:0] sb;
    logic signed [2*DATA_W+1:0] prod;
    sa   = {{(DATA_W+2){is_signed & a[DATA_W-1]}}, a};
    sb   = {{(DATA_W+2){is_signed & b[DATA_W-1]}}, b};
    prod = sa * sb;
    return prod[2*DATA_W-1:0];
  endfunction

  // Magnitude divide with sign fix-up: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  function automatic logic [2*DATA_W-1:0] div_core(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              is_signed
  );
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    neg_a = is_signed & a[DATA_W-1];
    neg_b = is_signed & b[DATA_W-1];
    mag_a = neg_a ? (~a + 1'b1) : a;
    mag_b = neg_b ? (~b + 1'b1) : b;
    quo   = mag_a / mag_b;
    rem   = mag_a % mag_b;
    if (neg_a ^ neg_b) quo = ~quo + 1'b1;
    if (neg_a)         rem = ~rem + 1'b1;
    return {rem, quo};
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   hi, hi_nxt;
  logic [DATA_W-1:0]   lo, lo_nxt;
  logic [DATA_W-1:0]   pend_hi, pend_hi_nxt;
  logic [DATA_W-1:0]   pend_lo, pend_lo_nxt;
  logic                div_zero, div_zero_nxt;
  logic                done_nxt;
  logic [2*DATA_W-1:0] mul_res;
  logic [2*DATA_W-1:0] div_res;

  assign mul_res = mul_core(E_A, E_B, E_op == OP_MULT);
  assign div_res = div_core(E_A, E_B, E_op == OP_DIV);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hi_nxt       = hi;
    lo_nxt       = lo;
    pend_hi_nxt  = pend_hi;
    pend_lo_nxt  = pend_lo;
    div_zero_nxt = div_zero;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (E_start) begin
          case (E_op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_nxt, pend_lo_nxt} = mul_res;
              div_zero_nxt = 1'b0;
              cnt_nxt      = CNT_W'(MULT_CYCLES);
              state_nxt    = MUL;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still occupies the unit but never commits.
              div_zero_nxt = (E_B == '0);
              if (E_B != '0) {pend_hi_nxt, pend_lo_nxt} = div_res;
              cnt_nxt      = CNT_W'(DIV_CYCLES);
              state_nxt    = DIV;
            end
            OP_MTHI: hi_nxt = E_A;
            OP_MTLO: lo_nxt = E_A;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          if (!(state == DIV && div_zero)) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      pend_hi  <= pend_hi_nxt;
      pend_lo  <= pend_lo_nxt;
      div_zero <= div_zero_nxt;
      done     <= done_nxt;
    end
  end

  assign busy  = (state != IDLE);
  assign stall = D_is_mdu & (busy | (E_start & (E_op <= OP_DIVU)));

  // Reads see committed HI/LO only; pending results stay invisible.
  always_comb begin
    E_MDU_Result = '0;
    case (E_op)
      OP_MFHI: E_MDU_Result = hi;
      OP_MFLO: E_MDU_Result = lo;
      default: E_MDU_Result = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, stall/reset sequences and
// randomized traffic against a cycle-count/arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_mdu;
  logic [31:0] E_MDU_Result;
  logic        busy;
  logic        stall;
  logic        done;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_op(E_op),
    .E_A(E_A), .E_B(E_B), .D_is_mdu(D_is_mdu),
    .E_MDU_Result(E_MDU_Result), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  int n_cmp;
  int n_bad;

  // Reference model: architectural HI/LO plus remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_zero;
  bit          m_done;

  logic        obs_busy;
  logic        obs_stall;
  logic [31:0] obs_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    m_left = 0; m_zero = 0; m_done = 0;
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit zero);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0; zero = 0;
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 0) zero = 1;
        else begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end
      end
      default: begin
        if (b == 0) zero = 1;
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] h, l;
    bit z;
    if (reset !== 1'b1) begin
      model_clear();
      return;
    end
    if (m_left > 0) begin
      m_done = (m_left == 1);
      if (m_left == 1 && !m_zero) begin m_hi = m_phi; m_lo = m_plo; end
      m_left--;
    end else begin
      m_done = 0;
      if (E_start) begin
        if (E_op <= 3'd3) begin
          ref_op(E_op, E_A, E_B, h, l, z);
          m_zero = z;
          if (!z) begin m_phi = h; m_plo = l; end
          m_left = (E_op <= 3'd1) ? MC : DC;
        end else if (E_op == 3'd6) m_hi = E_A;
        else if (E_op == 3'd7) m_lo = E_A;
      end
    end
  endtask

  task automatic cycle(input bit st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit d);
    logic [31:0] er;
    bit          es;
    @(negedge clk);
    reset = 1'b1;
    E_start = st; E_op = op; E_A = a; E_B = b; D_is_mdu = d;
    #1;
    obs_busy = busy; obs_stall = stall; obs_res = E_MDU_Result;
    er = (op == 3'd4) ? m_hi : (op == 3'd5) ? m_lo : 32'h0;
    es = d & ((m_left > 0) | (st & (op <= 3'd3)));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("stall", 32'(stall), 32'(es));
    chk("result", E_MDU_Result, er);
    @(posedge clk);
    model_edge();
  endtask

  // Leaves reset asserted; the next cycle() call releases it.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    E_start = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    E_op = 3'd4;
    #1 chk("rst_hi", E_MDU_Result, 32'h0);
    E_op = 3'd5;
    #1 chk("rst_lo", E_MDU_Result, 32'h0);
    model_clear();
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    int exp_nb;
    exp_nb = (v.op <= 3'd1) ? MC : (v.op <= 3'd3) ? DC : 0;
    nb = 0;
    cycle(1'b1, v.op, v.a, v.b, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      if (obs_busy !== 1'b1) break;
      nb++;
    end
    chk("busy_len", nb, exp_nb);
    cycle(1'b1, 3'd4, 32'h0, 32'h0, 1'b0);
    chk("vec_hi", obs_res, v.hi);
    cycle(1'b1, 3'd5, 32'h0, 32'h0, 1'b0);
    chk("vec_lo", obs_res, v.lo);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   nst;
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; E_start = 1'b0; E_op = 3'd4; E_A = '0; E_B = '0; D_is_mdu = 1'b0;
    model_clear();
    #3;
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_done", 32'(done), 32'h0);
    chk("init_hi", E_MDU_Result, 32'h0);

    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFD, 32'h5,         32'h0000_0004, 32'hFFFF_FFF1};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd3, 32'h7,         32'h2,         32'h1,         32'h3};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[5]  = '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    vecs[6]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    vecs[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[8]  = '{3'd6, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0};
    vecs[9]  = '{3'd7, 32'h0,         32'h0,         32'h1234_5678, 32'h0};
    vecs[10] = '{3'd2, 32'h55,        32'h0,         32'h1234_5678, 32'h0};
    vecs[11] = '{3'd3, 32'h9,         32'h0,         32'h1234_5678, 32'h0};
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Stall over start + busy window; the start inside busy must be dropped.
    nst = 0;
    cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b1); if (obs_stall === 1'b1) nst++;
    cycle(1'b1, 3'd0, 32'd7, 32'd7, 1'b1); if (obs_stall === 1'b1) nst++;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      if (obs_stall === 1'b1) nst++;
    end
    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("stall_after", 32'(obs_stall), 32'h0);
    chk("stall_count", nst, 6);
    cycle(1'b1, 3'd4, 32'h0, 32'h0, 1'b0);
    chk("ign_hi", obs_res, 32'h0);
    cycle(1'b1, 3'd5, 32'h0, 32'h0, 1'b0);
    chk("ign_lo", obs_res, 32'd12);

    // Reset in the third busy cycle of a DIV, then MULTU right after release.
    cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    do_reset();
    v = '{3'd1, 32'h0001_0000, 32'h0001_0001, 32'h1, 32'h0001_0000};
    run_vec(v);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle(($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), rnd_val(),
            ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
